mem_rmw_ctrl: RTL and testbench
===============================

MEM_RMW_CTRL -- requirements
Module: mem_rmw_ctrl

Interface
REQ-001 Parameter: MEM_AW, default 11, word-address width of the data RAM port.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 iReq  input  1  request strobe, sampled only in IDLE.
REQ-005 iWe  input  1  1 = store, 0 = load.
REQ-006 iAddr  input  32  byte address; bits [MEM_AW+1:2] select word, bits [1:0] are the position.
REQ-007 iWData  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-008 iType  input  `EXT_MEM_CWIDTH  access size, `MEM_WTYPE_WORD/HALF/BYTE codes from defines.vh.
REQ-009 iSigned  input  1  load sign-extension enable.
REQ-010 roBusy  output  1  high from request acceptance until the cycle after roDone.
REQ-011 roDone  output  1  one-cycle completion pulse.
REQ-012 roErr  output  1  misalignment flag, valid with roDone.
REQ-013 roRData  output  32  load result, right-aligned and extended, valid with roDone.
REQ-014 roMemAddr  output  MEM_AW  RAM word address.
REQ-015 roMemWe  output  1  RAM write enable.
REQ-016 roMemWData  output  32  RAM write data.
REQ-017 iMemRData  input  32  RAM read data, one cycle after the address is presented (synchronous read).

Function
REQ-018 FSM states: IDLE, RD, WAIT, WR, DONE; all outputs registered.
REQ-019 IDLE and iReq=1: latch iAddr, iWData, iType, iWe, iSigned; set roBusy=1.
REQ-020 Alignment check at acceptance: HALF with iAddr[0]=1, or WORD with iAddr[1:0]!=0, is misaligned; go to DONE with roErr=1, no RAM write.
REQ-021 Aligned store with WORD type: IDLE -> WR; roMemWData=iWData, roMemWe=1 for exactly one cycle.
REQ-022 Aligned store with HALF/BYTE type: IDLE -> RD -> WAIT -> WR (read-modify-write).
REQ-023 Aligned load: IDLE -> RD -> WAIT -> DONE.
REQ-024 RD presents roMemAddr with roMemWe=0; WAIT captures iMemRData into an internal original-word register.
REQ-025 WR merge rule: HALF pos 00 -> {ori[31:16],new[15:0]}; HALF pos 10 -> {new[15:0],ori[15:0]}; BYTE pos p -> replace ori byte p with new[7:0], other bytes unchanged.
REQ-026 Load extraction: WORD -> word; HALF -> bits [16*pos[1]+15 : 16*pos[1]]; BYTE -> byte pos; extension is the sign bit if iSigned=1, otherwise zero.
REQ-027 WR -> DONE; DONE asserts roDone=1 for one cycle, then -> IDLE with roBusy=0.
REQ-028 Latency from iReq to roDone: word store 2 cycles, sub-word store 4, load 3, error 1.
REQ-029 roMemAddr holds the latched word address from acceptance to DONE.
REQ-030 iReq during roBusy=1 is ignored; no queueing.
REQ-031 iReq in the DONE cycle is ignored; the earliest next acceptance is the first IDLE cycle.
REQ-032 roRData and roErr hold their values until the next roDone.
REQ-033 roErr is cleared at acceptance of every new request.
REQ-034 Unknown iType codes are treated as a load/store of zero bytes: no write; loads return the word; roErr=0.

Reset
REQ-035 rst=1 forces, asynchronously: state=IDLE; roBusy=0, roDone=0, roErr=0, roMemWe=0, roRData=0, roMemAddr=0, roMemWData=0.
REQ-036 rst asserted mid-operation, including WR, drops roMemWe within the same cycle and abandons the request; no completion pulse follows.

Verification
REQ-037 RAM[5]=0x11223344; BYTE store 0xAB at addr 0x16 -> RAM[5]=0x11AB3344, roDone at cycle 4, roErr=0.
REQ-038 RAM[5]=0x11223344; HALF store 0xBEEF at addr 0x14 -> RAM[5]=0x1122BEEF; word store 0xCAFEF00D at addr 0x14 -> one write, roDone at cycle 2.
REQ-039 RAM[5]=0x80FF7F01 -> signed BYTE load at 0x15 gives 0x0000007F; signed HALF load at 0x16 gives 0xFFFF80FF; unsigned BYTE load at 0x16 gives 0x000000FF.
REQ-040 HALF store at addr 0x15 -> roErr=1 with roDone one cycle after iReq, roMemWe never asserted, RAM unchanged.
REQ-041 rst pulsed during WAIT of a BYTE store -> roMemWe never asserted, RAM unchanged, all outputs 0, next request completes normally.
REQ-042 iReq held high continuously -> requests accepted back-to-back only from IDLE; exactly one roDone pulse per accepted request.

Source files
------------

// File: rtl/mem_rmw_ctrl_if.sv
// Access-size codes and the request/RAM bundle shared by the RMW controller and its requester.
// The master side drives requests and returns RAM read data; the slave side is the controller.
package mem_rmw_ctrl_pkg;
  localparam int unsigned EXT_MEM_CWIDTH = 2;
  localparam logic [EXT_MEM_CWIDTH-1:0] MEM_WTYPE_BYTE = 2'd0;
  localparam logic [EXT_MEM_CWIDTH-1:0] MEM_WTYPE_HALF = 2'd1;
  localparam logic [EXT_MEM_CWIDTH-1:0] MEM_WTYPE_WORD = 2'd2;
endpackage

interface mem_rmw_ctrl_if #(
  parameter int unsigned MEM_AW = 11
);
  logic                                       iReq;
  logic                                       iWe;
  logic [31:0]                                iAddr;
  logic [31:0]                                iWData;
  logic [mem_rmw_ctrl_pkg::EXT_MEM_CWIDTH-1:0] iType;
  logic                                       iSigned;
  logic                                       roBusy;
  logic                                       roDone;
  logic                                       roErr;
  logic [31:0]                                roRData;
  logic [MEM_AW-1:0]                          roMemAddr;
  logic                                       roMemWe;
  logic [31:0]                                roMemWData;
  logic [31:0]                                iMemRData;

  modport master (
    output iReq, iWe, iAddr, iWData, iType, iSigned, iMemRData,
    input  roBusy, roDone, roErr, roRData, roMemAddr, roMemWe, roMemWData
  );

  modport slave (
    input  iReq, iWe, iAddr, iWData, iType, iSigned, iMemRData,
    output roBusy, roDone, roErr, roRData, roMemAddr, roMemWe, roMemWData
  );
endinterface

// File: rtl/mem_rmw_ctrl.sv
// Byte/half/word load-store controller over a 32-bit synchronous-read RAM.
// Sub-word stores are done as read-modify-write; all outputs are registered.
module mem_rmw_ctrl #(
  parameter int unsigned MEM_AW = 11
) (
  input  logic          clk,
  input  logic          rst,
  mem_rmw_ctrl_if.slave bus
);
  import mem_rmw_ctrl_pkg::*;

  localparam int unsigned DW = 32;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e                    state_q;
  logic                      we_q;
  logic                      signed_q;
  logic [EXT_MEM_CWIDTH-1:0] type_q;
  logic [1:0]                pos_q;
  logic [15:0]               wdata_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      err_q;
  logic                      mem_we_q;
  logic [DW-1:0]             rdata_q;
  logic [DW-1:0]             mem_wdata_q;
  logic [MEM_AW-1:0]         mem_addr_q;

  logic                      misalign_c;
  logic                      known_c;
  logic [15:0]               half_c;
  logic [7:0]                byte_c;
  logic [DW-1:0]             merge_d;
  logic [DW-1:0]             load_d;
  logic                      unused_addr_c;

  // Upper byte-address bits lie outside the RAM and are intentionally dropped.
  assign unused_addr_c = ^bus.iAddr[DW-1:MEM_AW+2];

  always_comb begin
    misalign_c = 1'b0;
    known_c    = 1'b1;
    case (bus.iType)
      MEM_WTYPE_HALF: misalign_c = bus.iAddr[0];
      MEM_WTYPE_WORD: misalign_c = |bus.iAddr[1:0];
      MEM_WTYPE_BYTE: misalign_c = 1'b0;
      default:        known_c    = 1'b0;
    endcase
  end

  // Sub-word selection from the word returned by the RAM.
  always_comb begin
    half_c = pos_q[1] ? bus.iMemRData[31:16] : bus.iMemRData[15:0];
    case (pos_q)
      2'd0:    byte_c = bus.iMemRData[7:0];
      2'd1:    byte_c = bus.iMemRData[15:8];
      2'd2:    byte_c = bus.iMemRData[23:16];
      default: byte_c = bus.iMemRData[31:24];
    endcase
  end

  always_comb begin
    merge_d = bus.iMemRData;
    load_d  = bus.iMemRData;
    case (type_q)
      MEM_WTYPE_HALF: begin
        if (pos_q[1]) merge_d[31:16] = wdata_q;
        else          merge_d[15:0]  = wdata_q;
        load_d = {{16{signed_q & half_c[15]}}, half_c};
      end
      MEM_WTYPE_BYTE: begin
        case (pos_q)
          2'd0:    merge_d[7:0]   = wdata_q[7:0];
          2'd1:    merge_d[15:8]  = wdata_q[7:0];
          2'd2:    merge_d[23:16] = wdata_q[7:0];
          default: merge_d[31:24] = wdata_q[7:0];
        endcase
        load_d = {{24{signed_q & byte_c[7]}}, byte_c};
      end
      default: begin
        merge_d = bus.iMemRData;
        load_d  = bus.iMemRData;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      signed_q    <= 1'b0;
      type_q      <= '0;
      pos_q       <= '0;
      wdata_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      mem_we_q    <= 1'b0;
      rdata_q     <= '0;
      mem_wdata_q <= '0;
      mem_addr_q  <= '0;
    end else begin
      done_q   <= 1'b0;
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.iReq) begin
            we_q       <= bus.iWe;
            signed_q   <= bus.iSigned;
            type_q     <= bus.iType;
            pos_q      <= bus.iAddr[1:0];
            wdata_q    <= bus.iWData[15:0];
            mem_addr_q <= bus.iAddr[MEM_AW+1:2];
            busy_q     <= 1'b1;
            err_q      <= 1'b0;
            if (misalign_c) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (bus.iWe && bus.iType == MEM_WTYPE_WORD) begin
              mem_we_q    <= 1'b1;
              mem_wdata_q <= bus.iWData;
              state_q     <= S_WR;
            end else if (bus.iWe && !known_c) begin
              // Zero-byte store: nothing to write, complete immediately.
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              state_q <= S_RD;
            end
          end
        end
        S_RD: state_q <= S_WAIT;
        S_WAIT: begin
          if (we_q) begin
            mem_we_q    <= 1'b1;
            mem_wdata_q <= merge_d;
            state_q     <= S_WR;
          end else begin
            rdata_q <= load_d;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_WR: begin
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.roBusy     = busy_q;
  assign bus.roDone     = done_q;
  assign bus.roErr      = err_q;
  assign bus.roRData    = rdata_q;
  assign bus.roMemAddr  = mem_addr_q;
  assign bus.roMemWe    = mem_we_q;
  assign bus.roMemWData = mem_wdata_q;

endmodule

// File: tb/tb_mem_rmw_ctrl.sv
// Bench for mem_rmw_ctrl: RAM model plus a scoreboard of expected completions
// (error flag, load data, latency) checked whenever roDone pulses.
module tb_mem_rmw_ctrl;
  import mem_rmw_ctrl_pkg::*;

  localparam int unsigned MEM_AW = 11;
  localparam logic [1:0]  T_BAD  = 2'd3;

  typedef struct {
    string       tag;
    logic        err;
    logic [31:0] rdata;
    int unsigned lat;
    int unsigned start;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mem_rmw_ctrl_if #(.MEM_AW(MEM_AW)) bus ();

  mem_rmw_ctrl #(.MEM_AW(MEM_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0]       ram [0:(1<<MEM_AW)-1];
  logic              poke_en = 1'b0;
  logic [MEM_AW-1:0] poke_addr = '0;
  logic [31:0]       poke_data = '0;
  int unsigned       wr_cnt = 0;
  int unsigned       cyc = 0;
  int unsigned       done_cnt = 0;
  int unsigned       n_chk = 0;
  int unsigned       n_fail = 0;
  logic [31:0]       mdl_rdata = '0;
  exp_t              sb [$];

  // Synchronous-read RAM with a back-door preload port.
  always @(posedge clk) begin
    if (poke_en) ram[poke_addr] <= poke_data;
    else if (bus.roMemWe) begin
      ram[bus.roMemAddr] <= bus.roMemWData;
      wr_cnt <= wr_cnt + 1;
    end
    bus.iMemRData <= ram[bus.roMemAddr];
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Completion monitor: every roDone must match the oldest outstanding expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!rst && bus.roDone) begin
      done_cnt++;
      if (sb.size() == 0) check_eq("unexpected_done", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        check_eq({e.tag, "_err"}, 32'(bus.roErr), 32'(e.err));
        check_eq({e.tag, "_rdata"}, bus.roRData, e.rdata);
        check_eq({e.tag, "_lat"}, 32'(cyc - e.start), 32'(e.lat));
        check_eq({e.tag, "_busy"}, 32'(bus.roBusy), 32'd1);
      end
    end
  end

  task automatic poke(input logic [MEM_AW-1:0] a, input logic [31:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((sb.size() != 0 || bus.roBusy) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_complete"}, 32'(n < 40), 32'd1);
    if (n >= 40) sb.delete();
  endtask

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] typ, input logic sgn);
    bus.iWe = we; bus.iAddr = addr; bus.iWData = wdata; bus.iType = typ; bus.iSigned = sgn;
  endtask

  task automatic issue(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [1:0] typ, input logic sgn,
                       input logic exp_err, input int unsigned exp_lat, input logic [31:0] ld_val);
    exp_t e;
    @(negedge clk);
    drive(we, addr, wdata, typ, sgn);
    bus.iReq = 1'b1;
    if (!we && !exp_err) mdl_rdata = ld_val;
    e = '{tag, exp_err, mdl_rdata, exp_lat, cyc};
    sb.push_back(e);
    @(negedge clk);
    bus.iReq = 1'b0;
    wait_idle(tag);
  endtask

  initial begin
    int unsigned w0;
    int unsigned d0;
    int unsigned s;
    exp_t e;

    bus.iReq = 1'b0;
    drive(1'b0, 32'd0, 32'd0, MEM_WTYPE_WORD, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("rst_busy",  32'(bus.roBusy), 32'd0);
    check_eq("rst_done",  32'(bus.roDone), 32'd0);
    check_eq("rst_err",   32'(bus.roErr), 32'd0);
    check_eq("rst_we",    32'(bus.roMemWe), 32'd0);
    check_eq("rst_rdata", bus.roRData, 32'd0);
    check_eq("rst_addr",  32'(bus.roMemAddr), 32'd0);
    check_eq("rst_wdata", bus.roMemWData, 32'd0);
    rst = 1'b0;

    // Sub-word and word stores.
    poke(11'd5, 32'h11223344);
    w0 = wr_cnt;
    issue("st_byte", 1'b1, 32'h16, 32'h000000AB, MEM_WTYPE_BYTE, 1'b0, 1'b0, 4, 32'd0);
    check_eq("st_byte_ram", ram[5], 32'h11AB3344);
    check_eq("st_byte_wrs", 32'(wr_cnt - w0), 32'd1);

    poke(11'd5, 32'h11223344);
    issue("st_half", 1'b1, 32'h14, 32'h0000BEEF, MEM_WTYPE_HALF, 1'b0, 1'b0, 4, 32'd0);
    check_eq("st_half_ram", ram[5], 32'h1122BEEF);

    issue("st_half_hi", 1'b1, 32'h16, 32'h00005A5A, MEM_WTYPE_HALF, 1'b0, 1'b0, 4, 32'd0);
    check_eq("st_half_hi_ram", ram[5], 32'h5A5ABEEF);

    w0 = wr_cnt;
    issue("st_word", 1'b1, 32'h14, 32'hCAFEF00D, MEM_WTYPE_WORD, 1'b0, 1'b0, 2, 32'd0);
    check_eq("st_word_ram", ram[5], 32'hCAFEF00D);
    check_eq("st_word_wrs", 32'(wr_cnt - w0), 32'd1);

    // Loads with and without sign extension.
    poke(11'd5, 32'h80FF7F01);
    issue("ld_sb15", 1'b0, 32'h15, 32'd0, MEM_WTYPE_BYTE, 1'b1, 1'b0, 3, 32'h0000007F);
    issue("ld_sh16", 1'b0, 32'h16, 32'd0, MEM_WTYPE_HALF, 1'b1, 1'b0, 3, 32'hFFFF80FF);
    issue("ld_ub16", 1'b0, 32'h16, 32'd0, MEM_WTYPE_BYTE, 1'b0, 1'b0, 3, 32'h000000FF);
    issue("ld_sb17", 1'b0, 32'h17, 32'd0, MEM_WTYPE_BYTE, 1'b1, 1'b0, 3, 32'hFFFFFF80);
    issue("ld_uh14", 1'b0, 32'h14, 32'd0, MEM_WTYPE_HALF, 1'b0, 1'b0, 3, 32'h00007F01);
    issue("ld_word", 1'b0, 32'h14, 32'd0, MEM_WTYPE_WORD, 1'b1, 1'b0, 3, 32'h80FF7F01);

    // Misalignment: error in one cycle, no write, load data held.
    w0 = wr_cnt;
    issue("mis_half", 1'b1, 32'h15, 32'h0000BEEF, MEM_WTYPE_HALF, 1'b0, 1'b1, 1, 32'd0);
    issue("mis_word", 1'b0, 32'h16, 32'd0, MEM_WTYPE_WORD, 1'b0, 1'b1, 1, 32'd0);
    check_eq("mis_wrs", 32'(wr_cnt - w0), 32'd0);
    check_eq("mis_ram", ram[5], 32'h80FF7F01);
    issue("err_clear", 1'b0, 32'h14, 32'd0, MEM_WTYPE_BYTE, 1'b0, 1'b0, 3, 32'h00000001);

    // Unknown size code: zero-byte store, word load.
    w0 = wr_cnt;
    issue("bad_st", 1'b1, 32'h14, 32'h12345678, T_BAD, 1'b0, 1'b0, 1, 32'd0);
    check_eq("bad_st_wrs", 32'(wr_cnt - w0), 32'd0);
    issue("bad_ld", 1'b0, 32'h16, 32'd0, T_BAD, 1'b1, 1'b0, 3, 32'h80FF7F01);

    // Reset during WAIT of a byte store.
    poke(11'd5, 32'h11223344);
    w0 = wr_cnt;
    d0 = done_cnt;
    @(negedge clk);
    drive(1'b1, 32'h16, 32'h000000AB, MEM_WTYPE_BYTE, 1'b0);
    bus.iReq = 1'b1;
    @(negedge clk);
    bus.iReq = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_busy",  32'(bus.roBusy), 32'd0);
    check_eq("mid_rst_done",  32'(bus.roDone), 32'd0);
    check_eq("mid_rst_we",    32'(bus.roMemWe), 32'd0);
    check_eq("mid_rst_rdata", bus.roRData, 32'd0);
    check_eq("mid_rst_addr",  32'(bus.roMemAddr), 32'd0);
    check_eq("mid_rst_wdata", bus.roMemWData, 32'd0);
    mdl_rdata = 32'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("mid_rst_wrs",  32'(wr_cnt - w0), 32'd0);
    check_eq("mid_rst_ram",  ram[5], 32'h11223344);
    check_eq("mid_rst_dones", 32'(done_cnt - d0), 32'd0);
    issue("post_rst", 1'b0, 32'h16, 32'd0, MEM_WTYPE_BYTE, 1'b1, 1'b0, 3, 32'h00000022);

    // iReq held high: loads accepted every fourth cycle, one roDone each.
    d0 = done_cnt;
    @(negedge clk);
    drive(1'b0, 32'h14, 32'd0, MEM_WTYPE_WORD, 1'b0);
    bus.iReq = 1'b1;
    s = cyc;
    mdl_rdata = 32'h11223344;
    for (int k = 0; k < 3; k++) begin
      e = '{"held", 1'b0, mdl_rdata, 3, s + 4 * k};
      sb.push_back(e);
    end
    repeat (10) @(negedge clk);
    bus.iReq = 1'b0;
    wait_idle("held");
    check_eq("held_dones", 32'(done_cnt - d0), 32'd3);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
